// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_J = 3'd3,
    FMT_U = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_FMT   = 2'd3
  } enc_err_e;

  // addi x0, x0, 0 -- emitted in place of any word that fails its checks
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate range/alignment check and bit scatter into an RV32I word.
module imm_pack
  import instr_enc_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [31:0] i_imm,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_instr,
  output enc_err_e    o_err
);

  logic [31:0] w_raw;
  logic        w_legal;
  logic        w_fit;
  logic        w_align;

  // Per-format range/alignment test and field scatter, then error priority and NOP substitution
  always_comb begin
    w_raw   = '0;
    w_legal = 1'b1;
    w_fit   = 1'b1;
    w_align = 1'b1;
    case (i_fmt)
      FMT_I: begin
        w_fit = (&i_imm[31:11]) | ~(|i_imm[31:11]);
        w_raw = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
      end
      FMT_S: begin
        w_fit = (&i_imm[31:11]) | ~(|i_imm[31:11]);
        w_raw = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
      end
      FMT_B: begin
        w_fit   = (&i_imm[31:12]) | ~(|i_imm[31:12]);
        w_align = ~i_imm[0];
        w_raw   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
      end
      FMT_J: begin
        w_fit   = (&i_imm[31:20]) | ~(|i_imm[31:20]);
        w_align = ~i_imm[0];
        w_raw   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      end
      FMT_U: begin
        w_align = ~(|i_imm[11:0]);
        w_raw   = {i_imm[31:12], i_rd, i_opcode};
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal)      o_err = ERR_FMT;
    else if (!w_align) o_err = ERR_ALIGN;
    else if (!w_fit)   o_err = ERR_RANGE;
    else               o_err = ERR_OK;

    o_instr = (o_err == ERR_OK) ? w_raw : NOP_INSTR;
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage pipelined RV32I instruction encoder with valid/ready streams and status counters.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      w_instr;
  enc_err_e         w_err;
  logic             w_s2_load;
  logic             w_in_hs;
  logic             w_out_hs;

  logic             r_s1_v;
  logic [31:0]      r_s1_instr;
  enc_err_e         r_s1_err;
  logic             r_s2_v;
  logic [31:0]      r_out_instr;
  enc_err_e         r_out_err;
  logic [CNT_W-1:0] r_enc_count;
  logic [CNT_W-1:0] r_err_count;

  imm_pack u_imm_pack (
    .i_fmt    (in_fmt),
    .i_imm    (in_imm),
    .i_opcode (in_opcode),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_funct3 (in_funct3),
    .o_instr  (w_instr),
    .o_err    (w_err)
  );

  // S2 may load whenever it is empty or its word leaves this cycle; S1 may then refill too
  assign w_s2_load = ~r_s2_v | out_ready;
  assign in_ready  = ~r_s1_v | ~r_s2_v | out_ready;
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = r_s2_v & out_ready;

  // Stage 1: capture the checked/packed word on an input handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_instr <= '0;
      r_s1_err   <= ERR_OK;
    end else if (w_in_hs) begin
      r_s1_v     <= 1'b1;
      r_s1_instr <= w_instr;
      r_s1_err   <= w_err;
    end else if (w_s2_load) begin
      r_s1_v     <= 1'b0;
    end
  end

  // Stage 2: output register, held stable while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v      <= 1'b0;
      r_out_instr <= '0;
      r_out_err   <= ERR_OK;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_out_instr <= r_s1_instr;
        r_out_err   <= r_s1_err;
      end
    end
  end

  // Saturating counters of emitted words, split by clean/erroring status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_out_hs) begin
      if (r_out_err == ERR_OK) begin
        if (r_enc_count != '1) r_enc_count <= r_enc_count + CNT_W'(1);
      end else begin
        if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_s2_v;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, randomized stalls, reset and saturation.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  // narrow-counter copy fed the same stream, used to reach saturation quickly
  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_instr;
  logic [1:0]  s_out_err;
  logic [2:0]  s_enc_count;
  logic [2:0]  s_err_count;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
  );

  instr_encoder #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_err(s_out_err), .enc_count(s_enc_count), .err_count(s_err_count)
  );

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
  } req_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  req_t q[$];
  int   exp_enc  = 0;
  int   exp_errc = 0;

  // Error code from the format's legal numeric range and required alignment
  function automatic logic [1:0] ref_err(input req_t r);
    int v;
    v = $signed(r.imm);
    if (r.fmt > 3'd4) return 2'd3;
    if ((r.fmt == 3'd2 || r.fmt == 3'd3) && (v % 2 != 0)) return 2'd2;
    if (r.fmt == 3'd4 && (v % 4096 != 0)) return 2'd2;
    case (r.fmt)
      3'd0, 3'd1: if (v < -2048 || v > 2047) return 2'd1;
      3'd2:       if (v < -4096 || v > 4095) return 2'd1;
      3'd3:       if (v < -1048576 || v > 1048575) return 2'd1;
      default:    ;
    endcase
    return 2'd0;
  endfunction

  // Core-style immediate decode of an encoded word
  function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
    case (fmt)
      3'd0:    return {{20{w[31]}}, w[31:20]};
      3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {w[31:12], 12'h000};
    endcase
  endfunction

  function automatic req_t gen_req();
    req_t r;
    int unsigned c;
    r.op  = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.fmt = 3'($urandom_range(0, 4));
    c = $urandom_range(0, 9);
    if (c == 0) r.fmt = 3'($urandom_range(5, 7));
    if (c < 3) r.imm = $urandom;
    else begin
      case (r.fmt)
        3'd0, 3'd1: r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd2:       r.imm = 32'($urandom_range(0, 4095)) * 32'd2 - 32'd4096;
        3'd3:       r.imm = 32'($urandom_range(0, 1048575)) * 32'd2 - 32'd1048576;
        default:    r.imm = $urandom & 32'hFFFF_F000;
      endcase
    end
    return r;
  endfunction

  // One clock: drive after the falling edge, sample, and keep the accepted-request queue
  task automatic drive_cycle(input logic iv, input req_t r, input logic ordy,
                             output logic acc, output logic emit, output logic ov,
                             output logic have, output req_t ex,
                             output logic [31:0] oi, output logic [1:0] oe);
    @(negedge clk);
    in_valid  = iv;
    in_fmt    = r.fmt;
    in_opcode = r.op;
    in_rd     = r.rd;
    in_rs1    = r.rs1;
    in_rs2    = r.rs2;
    in_funct3 = r.f3;
    in_imm    = r.imm;
    out_ready = ordy;
    #1;
    acc  = iv && in_ready;
    ov   = out_valid;
    emit = out_valid && ordy;
    oi   = out_instr;
    oe   = out_err;
    have = 1'b0;
    ex   = '0;
    if (emit && q.size() > 0) begin
      ex   = q.pop_front();
      have = 1'b1;
      if (ref_err(ex) == 2'd0) exp_enc++;
      else exp_errc++;
    end
    if (acc) q.push_back(r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_tests++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got=%h exp=00000000", out_instr); end
    n_tests++; if (out_err !== 2'b00) begin n_fail++; $display("FAIL reset_out_err got=%b exp=00", out_err); end
    n_tests++; if (enc_count !== 16'd0) begin n_fail++; $display("FAIL reset_enc_count got=%0d exp=0", enc_count); end
    n_tests++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    req_t        tv[15];
    logic [31:0] ei[15];
    logic [1:0]  ee[15];
    logic acc, emit, ov, have;
    req_t ex;
    logic [31:0] oi;
    logic [1:0] oe;
    int lat;
    //            fmt   op        rd    rs1   rs2   f3    imm
    tv[0]  = {3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF}; ei[0]  = 32'hFFF1_0093; ee[0]  = 2'd0;
    tv[1]  = {3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_F000}; ei[1]  = 32'h8020_8063; ee[1]  = 2'd0;
    tv[2]  = {3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3};         ei[2]  = 32'h0000_0013; ee[2]  = 2'd2;
    tv[3]  = {3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096};      ei[3]  = 32'h0000_0013; ee[3]  = 2'd1;
    tv[4]  = {3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2046};      ei[4]  = 32'h7FE0_00EF; ee[4]  = 2'd0;
    tv[5]  = {3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000}; ei[5]  = 32'h1234_52B7; ee[5]  = 2'd0;
    tv[6]  = {3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h0000_0800}; ei[6]  = 32'h0000_0013; ee[6]  = 2'd2;
    tv[7]  = {3'd6, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0};         ei[7]  = 32'h0000_0013; ee[7]  = 2'd3;
    tv[8]  = {3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2047};      ei[8]  = 32'h7FF0_0013; ee[8]  = 2'd0;
    tv[9]  = {3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048};      ei[9]  = 32'h0000_0013; ee[9]  = 2'd1;
    tv[10] = {3'd1, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, 32'hFFFF_F800}; ei[10] = 32'h8041_A023; ee[10] = 2'd0;
    tv[11] = {3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4097};      ei[11] = 32'h0000_0013; ee[11] = 2'd2;
    tv[12] = {3'd5, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3};         ei[12] = 32'h0000_0013; ee[12] = 2'd3;
    tv[13] = {3'd3, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFF0_0000}; ei[13] = 32'h8000_006F; ee[13] = 2'd0;
    tv[14] = {3'd3, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0010_0000}; ei[14] = 32'h0000_0013; ee[14] = 2'd1;
    for (int i = 0; i < 15; i++) begin
      drive_cycle(1'b1, tv[i], 1'b1, acc, emit, ov, have, ex, oi, oe);
      n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL dir%0d_accept got=%b exp=1", i, acc); end
      lat  = 0;
      emit = 1'b0;
      while (!emit && lat < 6) begin
        drive_cycle(1'b0, tv[i], 1'b1, acc, emit, ov, have, ex, oi, oe);
        lat++;
      end
      n_tests++; if (!emit || lat != 2) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=2", i, emit ? lat : -1); end
      n_tests++; if (oi !== ei[i]) begin n_fail++; $display("FAIL dir%0d_instr got=%h exp=%h", i, oi, ei[i]); end
      n_tests++; if (oe !== ee[i]) begin n_fail++; $display("FAIL dir%0d_err got=%b exp=%b", i, oe, ee[i]); end
    end
    drive_cycle(1'b0, tv[0], 1'b0, acc, emit, ov, have, ex, oi, oe);
    n_tests++; if (enc_count !== 16'(exp_enc)) begin n_fail++; $display("FAIL dir_enc_count got=%0d exp=%0d", enc_count, exp_enc); end
    n_tests++; if (err_count !== 16'(exp_errc)) begin n_fail++; $display("FAIL dir_err_count got=%0d exp=%0d", err_count, exp_errc); end
  endtask

  task automatic test_random();
    logic acc, emit, ov, have, iv, ordy;
    req_t r, ex;
    logic [31:0] oi, prev_i;
    logic [1:0] oe, prev_e;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_i = '0;
    prev_e = '0;
    for (int c = 0; c < 620; c++) begin
      r    = gen_req();
      iv   = (c < 600) ? ($urandom_range(0, 3) != 0) : 1'b0;
      ordy = (c < 600) ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive_cycle(iv, r, ordy, acc, emit, ov, have, ex, oi, oe);
      if (prev_stall) begin
        n_tests++;
        if (ov !== 1'b1 || oi !== prev_i || oe !== prev_e) begin
          n_fail++;
          $display("FAIL rnd_stall_hold c=%0d got=%b/%h/%b exp=1/%h/%b", c, ov, oi, oe, prev_i, prev_e);
        end
      end
      prev_stall = ov && !ordy;
      prev_i = oi;
      prev_e = oe;
      if (emit) begin
        n_tests++;
        if (!have) begin n_fail++; $display("FAIL rnd_extra_word c=%0d got=%h exp=none", c, oi); end
        else if (oe !== ref_err(ex)) begin
          n_fail++; $display("FAIL rnd_err c=%0d got=%b exp=%b imm=%h fmt=%0d", c, oe, ref_err(ex), ex.imm, ex.fmt);
        end else if (oe != 2'd0) begin
          if (oi !== 32'h0000_0013) begin n_fail++; $display("FAIL rnd_nop c=%0d got=%h exp=00000013", c, oi); end
        end else begin
          if (decode_imm(ex.fmt, oi) !== ex.imm) begin
            n_fail++; $display("FAIL rnd_imm c=%0d got=%h exp=%h fmt=%0d", c, decode_imm(ex.fmt, oi), ex.imm, ex.fmt);
          end else if (oi[6:0] !== ex.op) begin
            n_fail++; $display("FAIL rnd_opcode c=%0d got=%h exp=%h", c, oi[6:0], ex.op);
          end else if ((ex.fmt == 3'd0 || ex.fmt == 3'd3 || ex.fmt == 3'd4) && oi[11:7] !== ex.rd) begin
            n_fail++; $display("FAIL rnd_rd c=%0d got=%0d exp=%0d", c, oi[11:7], ex.rd);
          end else if (ex.fmt <= 3'd2 && (oi[19:15] !== ex.rs1 || oi[14:12] !== ex.f3)) begin
            n_fail++; $display("FAIL rnd_rs1_f3 c=%0d got=%0d/%0d exp=%0d/%0d", c, oi[19:15], oi[14:12], ex.rs1, ex.f3);
          end else if ((ex.fmt == 3'd1 || ex.fmt == 3'd2) && oi[24:20] !== ex.rs2) begin
            n_fail++; $display("FAIL rnd_rs2 c=%0d got=%0d exp=%0d", c, oi[24:20], ex.rs2);
          end
        end
      end
    end
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_lost_words got=%0d exp=0", q.size()); end
    n_tests++; if (enc_count !== 16'(exp_enc)) begin n_fail++; $display("FAIL rnd_enc_count got=%0d exp=%0d", enc_count, exp_enc); end
    n_tests++; if (err_count !== 16'(exp_errc)) begin n_fail++; $display("FAIL rnd_err_count got=%0d exp=%0d", err_count, exp_errc); end
    n_tests++;
    if (s_enc_count !== 3'((exp_enc > 7) ? 7 : exp_enc) || s_err_count !== 3'((exp_errc > 7) ? 7 : exp_errc)) begin
      n_fail++; $display("FAIL rnd_narrow_counts got=%0d/%0d exp=%0d/%0d", s_enc_count, s_err_count,
                         (exp_enc > 7) ? 7 : exp_enc, (exp_errc > 7) ? 7 : exp_errc);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, emit, ov, have, ordy;
    req_t r, ex;
    logic [31:0] oi;
    logic [1:0] oe;
    int n_acc, n_emit_mid, k;
    n_acc = 0;
    n_emit_mid = 0;
    k = 0;
    r = {3'd0, 7'h13, 5'd7, 5'd9, 5'd0, 3'd0, 32'd0};
    for (int c = 0; c < 16; c++) begin
      r.imm = 32'(c * 3 - 10);
      ordy  = (c >= 2);
      drive_cycle(c < 10, r, ordy, acc, emit, ov, have, ex, oi, oe);
      if (acc) n_acc++;
      if (emit) begin
        if (c >= 2 && c < 10) n_emit_mid++;
        n_tests++;
        if (decode_imm(3'd0, oi) !== 32'(k * 3 - 10) || oe !== 2'd0) begin
          n_fail++; $display("FAIL b2b_order k=%0d got=%h/%b exp=%h/00", k, decode_imm(3'd0, oi), oe, 32'(k * 3 - 10));
        end
        k++;
      end
    end
    n_tests++; if (n_acc != 10) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=10", n_acc); end
    n_tests++; if (n_emit_mid != 8) begin n_fail++; $display("FAIL b2b_throughput got=%0d exp=8", n_emit_mid); end
    n_tests++; if (k != 10) begin n_fail++; $display("FAIL b2b_emitted got=%0d exp=10", k); end
  endtask

  task automatic test_reset_midstream();
    logic acc, emit, ov, have;
    req_t r, ex;
    logic [31:0] oi;
    logic [1:0] oe;
    int lat;
    r = {3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'hABCD_E000};
    drive_cycle(1'b1, r, 1'b0, acc, emit, ov, have, ex, oi, oe);
    drive_cycle(1'b1, r, 1'b0, acc, emit, ov, have, ex, oi, oe);
    drive_cycle(1'b0, r, 1'b0, acc, emit, ov, have, ex, oi, oe);
    n_tests++; if (ov !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_full_pipe got=%b/%b exp=1/0", ov, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    exp_enc  = 0;
    exp_errc = 0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid got=%b exp=0", out_valid); end
    n_tests++; if (enc_count !== 16'd0 || err_count !== 16'd0) begin n_fail++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", enc_count, err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    r.imm = 32'h0000_1000;
    drive_cycle(1'b1, r, 1'b1, acc, emit, ov, have, ex, oi, oe);
    n_tests++; if (acc !== 1'b1 || ov !== 1'b0) begin n_fail++; $display("FAIL rst_release_accept got=%b/%b exp=1/0", acc, ov); end
    lat = 0;
    emit = 1'b0;
    while (!emit && lat < 6) begin
      drive_cycle(1'b0, r, 1'b1, acc, emit, ov, have, ex, oi, oe);
      lat++;
    end
    n_tests++; if (!emit || lat != 2 || oi !== 32'h0000_11B7) begin n_fail++; $display("FAIL rst_next_word got=%0d/%h exp=2/000011b7", lat, oi); end
    drive_cycle(1'b0, r, 1'b1, acc, emit, ov, have, ex, oi, oe);
    n_tests++; if (emit !== 1'b0 || q.size() != 0) begin n_fail++; $display("FAIL rst_discard got=%b/%0d exp=0/0", emit, q.size()); end
  endtask

  task automatic test_saturation();
    logic acc, emit, ov, have;
    req_t r, ex;
    logic [31:0] oi;
    logic [1:0] oe;
    int base_enc, base_err;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    q.delete();
    exp_enc  = 0;
    exp_errc = 0;
    r = {3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 32'd0};
    for (int c = 0; c < 9; c++) drive_cycle(c < 6, r, 1'b1, acc, emit, ov, have, ex, oi, oe);
    n_tests++; if (s_err_count !== 3'd6) begin n_fail++; $display("FAIL sat_pre got=%0d exp=6", s_err_count); end
    base_enc = exp_enc;
    base_err = exp_errc;
    for (int c = 0; c < 6; c++) drive_cycle(c < 3, r, 1'b1, acc, emit, ov, have, ex, oi, oe);
    n_tests++; if (s_err_count !== 3'd7) begin n_fail++; $display("FAIL sat_err_count got=%0d exp=7", s_err_count); end
    n_tests++; if (s_enc_count !== 3'(base_enc)) begin n_fail++; $display("FAIL sat_enc_hold got=%0d exp=%0d", s_enc_count, base_enc); end
    n_tests++; if (err_count !== 16'(base_err + 3)) begin n_fail++; $display("FAIL sat_wide_err got=%0d exp=%0d", err_count, base_err + 3); end
    n_tests++; if (enc_count !== 16'd0) begin n_fail++; $display("FAIL sat_wide_enc got=%0d exp=0", enc_count); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
